// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared opcodes, pipeline constants and LSU state encoding
package mem_lsu_pkg;

    localparam int ALU_OP_W = 8;

    localparam logic [ALU_OP_W-1:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [ALU_OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALU_OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALU_OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALU_OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic        STOP         = 1'b1;
    localparam logic        NOSTOP       = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DONE   = 2'd2,
        LSU_ABORT  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: req/ack data-bus between the load/store unit and memory
interface mem_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_W/8-1:0]   sel;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;
    logic                  ack;

    modport master (output req, we, sel, addr, wdata, input rdata, ack);
    modport slave  (input req, we, sel, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: big-endian lane select, store replication, load extract/extend, misalign check
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] aluop_i,
    input  logic [1:0]          addr_i,
    input  logic [31:0]         rt_i,
    input  logic [31:0]         rdata_i,
    output logic                is_mem_o,
    output logic                is_load_o,
    output logic                misalign_o,
    output logic [3:0]          sel_o,
    output logic [31:0]         wdata_o,
    output logic [31:0]         ldata_o
);
    logic       byte_op;
    logic       half_op;
    logic       word_op;
    logic       sext;
    logic [7:0] b;
    logic [15:0] h;

    // decode access size and format the bus lanes for both directions
    always_comb begin
        byte_op    = aluop_i inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
        half_op    = aluop_i inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
        word_op    = aluop_i inside {EXE_LW_OP, EXE_SW_OP};
        sext       = aluop_i inside {EXE_LB_OP, EXE_LH_OP};
        is_load_o  = aluop_i inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
        is_mem_o   = byte_op | half_op | word_op;
        misalign_o = (half_op & addr_i[0]) | (word_op & (addr_i != 2'b00));
        sel_o      = byte_op ? (4'b1000 >> addr_i) :
                     half_op ? (addr_i[1] ? 4'b0011 : 4'b1100) :
                     word_op ? 4'b1111 : 4'b0000;
        wdata_o    = byte_op ? {4{rt_i[7:0]}} : half_op ? {2{rt_i[15:0]}} : rt_i;
        b          = addr_i == 2'd0 ? rdata_i[31:24] :
                     addr_i == 2'd1 ? rdata_i[23:16] :
                     addr_i == 2'd2 ? rdata_i[15:8]  : rdata_i[7:0];
        h          = addr_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        ldata_o    = byte_op ? {{24{sext & b[7]}}, b} :
                     half_op ? {{16{sext & h[15]}}, h} : rdata_i;
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with multi-cycle req/ack data-bus transactions
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALU_OP_W-1:0] aluop_i,
    input  logic [4:0]          wd_i,
    input  logic                wreg_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W-1:0]   reg2_i,
    input  logic [5:0]          stall_i,
    input  logic                flush_i,
    output logic [4:0]          wd_o,
    output logic                wreg_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic                stallreq_o,
    output logic                misalign_o,
    mem_lsu_if.master           bus
);
    lsu_state_e          state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [3:0]          sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   bwdata_q, bwdata_d;
    logic [DATA_W-1:0]   result_q, result_d;

    logic                is_mem;
    logic                is_load;
    logic                misalign;
    logic [3:0]          sel;
    logic [DATA_W-1:0]   st_data;
    logic [DATA_W-1:0]   ld_data;
    logic                unused_stall;

    assign unused_stall = ^{stall_i[5:4], stall_i[2:0]};

    mem_lsu_align u_align (
        .aluop_i    (aluop_i),
        .addr_i     (wdata_i[1:0]),
        .rt_i       (reg2_i),
        .rdata_i    (bus.rdata),
        .is_mem_o   (is_mem),
        .is_load_o  (is_load),
        .misalign_o (misalign),
        .sel_o      (sel),
        .wdata_o    (st_data),
        .ldata_o    (ld_data)
    );

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.sel   = sel_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = bwdata_q;

    // next state, bus register loads and MEM/WB outputs; EX/MEM inputs stay stable while we stall
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        bwdata_d   = bwdata_q;
        result_d   = result_q;
        wd_o       = wd_i;
        wreg_o     = 1'b0;
        wdata_o    = wdata_i;
        stallreq_o = 1'b0;
        misalign_o = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (!flush_i && !is_mem) begin
                    wreg_o = wreg_i;
                end else if (!flush_i && misalign) begin
                    misalign_o = 1'b1;
                end else if (!flush_i) begin
                    stallreq_o = 1'b1;
                    state_d    = LSU_ACCESS;
                    req_d      = 1'b1;
                    we_d       = !is_load;
                    sel_d      = sel;
                    addr_d     = {wdata_i[ADDR_W-1:2], 2'b00};
                    bwdata_d   = st_data;
                end
            end
            LSU_ACCESS: begin
                stallreq_o = 1'b1;
                if (bus.ack) begin
                    {req_d, we_d, sel_d, addr_d, bwdata_d} = '0;
                    result_d = flush_i ? result_q : ld_data;
                    state_d  = flush_i ? LSU_IDLE : LSU_DONE;
                end else if (flush_i) begin
                    state_d = LSU_ABORT;
                end
            end
            LSU_DONE: begin
                wreg_o  = wreg_i & !flush_i;
                wdata_o = is_load ? result_q : wdata_i;
                if (stall_i[3] == NOSTOP || flush_i) state_d = LSU_IDLE;
            end
            LSU_ABORT: begin
                stallreq_o = 1'b1;
                if (bus.ack) begin
                    {req_d, we_d, sel_d, addr_d, bwdata_d} = '0;
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
        if (!rst) begin
            wd_o       = NOP_REG_ADDR;
            wreg_o     = 1'b0;
            wdata_o    = '0;
            stallreq_o = 1'b0;
            misalign_o = 1'b0;
        end
    end

    // state, bus and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= LSU_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            addr_q   <= '0;
            bwdata_q <= '0;
            result_q <= ZERO_WORD;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            bwdata_q <= bwdata_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for the MEM-stage load/store unit
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [31:0] reg2_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic        misalign_o;
    int          tests_run = 0;
    int          tests_failed = 0;

    mem_lsu_if bus_if ();

    mem_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .reg2_i     (reg2_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq_o (stallreq_o),
        .misalign_o (misalign_o),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rt,
                         input logic [4:0] wd, input logic wr);
        aluop_i = op; wdata_i = a; reg2_i = rt; wd_i = wd; wreg_i = wr;
    endtask

    task automatic test_reset;
        rst = 0; drive(EXE_ADD_OP, 32'h99, 0, 5'd1, 1); stall_i = 0; flush_i = 0;
        bus_if.ack = 0; bus_if.rdata = 0;
        tick; tick; #1;
        tests_run++;
        if ({wd_o, wreg_o, wdata_o, stallreq_o, misalign_o, bus_if.req, bus_if.we, bus_if.sel, bus_if.addr, bus_if.wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset wd=%h wreg=%b wdata=%h stallreq=%b req=%b sel=%b addr=%h expected all zero",
                     wd_o, wreg_o, wdata_o, stallreq_o, bus_if.req, bus_if.sel, bus_if.addr);
        end
        tick; rst = 1; drive(EXE_ADD_OP, 0, 0, 0, 0);
    endtask

    task automatic test_passthrough;
        tick; drive(EXE_ADD_OP, 32'h1234, 0, 5'd3, 1); #1;
        tests_run++;
        if (wd_o !== 5'd3 || wreg_o !== 1 || wdata_o !== 32'h1234 || stallreq_o !== 0) begin
            tests_failed++;
            $display("FAIL add_pass wd=%0d wreg=%b wdata=%h stallreq=%b expected 3 1 00001234 0", wd_o, wreg_o, wdata_o, stallreq_o);
        end
        tick; drive(EXE_ADD_OP, 0, 0, 0, 0); #1;
        tests_run++;
        if (bus_if.req !== 0) begin
            tests_failed++;
            $display("FAIL add_noreq req=%b expected 0", bus_if.req);
        end
    endtask

    task automatic test_load_byte(input logic [7:0] op, input logic [31:0] exp);
        tick; drive(op, 32'h103, 0, 5'd5, 1); #1;
        tests_run++;
        if (stallreq_o !== 1 || wreg_o !== 0 || bus_if.req !== 0) begin
            tests_failed++;
            $display("FAIL lb_issue op=%h stallreq=%b wreg=%b req=%b expected 1 0 0", op, stallreq_o, wreg_o, bus_if.req);
        end
        tick; bus_if.rdata = 32'h0000_00F0; bus_if.ack = 1; #1;
        tests_run++;
        if ({bus_if.req, bus_if.we, bus_if.sel, bus_if.addr, stallreq_o, wreg_o} !== {1'b1, 1'b0, 4'b0001, 32'h100, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL lb_access op=%h req=%b we=%b sel=%b addr=%h stallreq=%b wreg=%b expected 1 0 0001 00000100 1 0",
                     op, bus_if.req, bus_if.we, bus_if.sel, bus_if.addr, stallreq_o, wreg_o);
        end
        tick; bus_if.ack = 0; #1;
        tests_run++;
        if (stallreq_o !== 0 || wreg_o !== 1 || wd_o !== 5'd5 || wdata_o !== exp || bus_if.req !== 0) begin
            tests_failed++;
            $display("FAIL lb_done op=%h stallreq=%b wreg=%b wd=%0d wdata=%h req=%b expected 0 1 5 %h 0",
                     op, stallreq_o, wreg_o, wd_o, wdata_o, bus_if.req, exp);
        end
        tick; drive(EXE_ADD_OP, 0, 0, 0, 0);
    endtask

    task automatic test_store_half;
        tick; drive(EXE_SH_OP, 32'h202, 32'hAAAA_1234, 5'd0, 0); #1;
        tests_run++;
        if (stallreq_o !== 1 || wreg_o !== 0) begin
            tests_failed++;
            $display("FAIL sh_issue stallreq=%b wreg=%b expected 1 0", stallreq_o, wreg_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick; bus_if.ack = (i == 3); #1;
            tests_run++;
            if ({bus_if.req, bus_if.we, bus_if.sel, bus_if.addr, bus_if.wdata, stallreq_o, wreg_o} !==
                {1'b1, 1'b1, 4'b0011, 32'h200, 32'h1234_1234, 1'b1, 1'b0}) begin
                tests_failed++;
                $display("FAIL sh_access%0d req=%b we=%b sel=%b addr=%h wdata=%h stallreq=%b wreg=%b expected 1 1 0011 00000200 12341234 1 0",
                         i, bus_if.req, bus_if.we, bus_if.sel, bus_if.addr, bus_if.wdata, stallreq_o, wreg_o);
            end
        end
        tick; bus_if.ack = 0; #1;
        tests_run++;
        if (stallreq_o !== 0 || wreg_o !== 0 || bus_if.req !== 0 || wdata_o !== 32'h202) begin
            tests_failed++;
            $display("FAIL sh_done stallreq=%b wreg=%b req=%b wdata=%h expected 0 0 0 00000202", stallreq_o, wreg_o, bus_if.req, wdata_o);
        end
        tick; drive(EXE_ADD_OP, 0, 0, 0, 0);
    endtask

    task automatic test_misalign;
        tick; drive(EXE_LW_OP, 32'h101, 0, 5'd7, 1); #1;
        tests_run++;
        if (misalign_o !== 1 || wreg_o !== 0 || stallreq_o !== 0) begin
            tests_failed++;
            $display("FAIL lw_misalign misalign=%b wreg=%b stallreq=%b expected 1 0 0", misalign_o, wreg_o, stallreq_o);
        end
        tick; drive(EXE_LH_OP, 32'h203, 0, 5'd7, 1); #1;
        tests_run++;
        if (misalign_o !== 1 || bus_if.req !== 0 || stallreq_o !== 0) begin
            tests_failed++;
            $display("FAIL lh_misalign misalign=%b req=%b stallreq=%b expected 1 0 0", misalign_o, bus_if.req, stallreq_o);
        end
        tick; drive(EXE_ADD_OP, 0, 0, 0, 0); #1;
        tests_run++;
        if (misalign_o !== 0 || bus_if.req !== 0) begin
            tests_failed++;
            $display("FAIL misalign_pulse misalign=%b req=%b expected 0 0", misalign_o, bus_if.req);
        end
    endtask

    task automatic test_flush_idle;
        tick; drive(EXE_LW_OP, 32'h600, 0, 5'd8, 1); flush_i = 1; #1;
        tests_run++;
        if (stallreq_o !== 0 || wreg_o !== 0) begin
            tests_failed++;
            $display("FAIL flush_idle stallreq=%b wreg=%b expected 0 0", stallreq_o, wreg_o);
        end
        tick; flush_i = 0; drive(EXE_ADD_OP, 0, 0, 0, 0); #1;
        tests_run++;
        if (bus_if.req !== 0) begin
            tests_failed++;
            $display("FAIL flush_idle_noreq req=%b expected 0", bus_if.req);
        end
    endtask

    task automatic test_flush_abort;
        tick; drive(EXE_LW_OP, 32'h300, 0, 5'd9, 1);
        tick; flush_i = 1; #1;
        tests_run++;
        if (bus_if.req !== 1 || stallreq_o !== 1 || wreg_o !== 0) begin
            tests_failed++;
            $display("FAIL abort_access req=%b stallreq=%b wreg=%b expected 1 1 0", bus_if.req, stallreq_o, wreg_o);
        end
        for (int i = 0; i < 2; i++) begin
            tick; flush_i = 0; bus_if.ack = (i == 1); bus_if.rdata = 32'hDEAD_BEEF; #1;
            tests_run++;
            if (bus_if.req !== 1 || stallreq_o !== 1 || wreg_o !== 0) begin
                tests_failed++;
                $display("FAIL abort_hold%0d req=%b stallreq=%b wreg=%b expected 1 1 0", i, bus_if.req, stallreq_o, wreg_o);
            end
        end
        tick; bus_if.ack = 0; drive(EXE_ADD_OP, 32'h55, 0, 5'd0, 0); #1;
        tests_run++;
        if (bus_if.req !== 0 || stallreq_o !== 0 || wreg_o !== 0 || wdata_o !== 32'h55) begin
            tests_failed++;
            $display("FAIL abort_idle req=%b stallreq=%b wreg=%b wdata=%h expected 0 0 0 00000055", bus_if.req, stallreq_o, wreg_o, wdata_o);
        end
    endtask

    task automatic test_stall_and_reset;
        tick; drive(EXE_LW_OP, 32'h400, 0, 5'd4, 1);
        tick; bus_if.rdata = 32'hCAFE_F00D; bus_if.ack = 1;
        for (int i = 0; i < 4; i++) begin
            tick; bus_if.ack = 0; stall_i = (i < 3) ? 6'b001000 : 6'b000000; #1;
            tests_run++;
            if (wreg_o !== 1 || wdata_o !== 32'hCAFE_F00D || wd_o !== 5'd4 || stallreq_o !== 0) begin
                tests_failed++;
                $display("FAIL stall_hold%0d wreg=%b wdata=%h wd=%0d stallreq=%b expected 1 cafef00d 4 0", i, wreg_o, wdata_o, wd_o, stallreq_o);
            end
        end
        tick; drive(EXE_ADD_OP, 32'h66, 0, 5'd0, 0); #1;
        tests_run++;
        if (wreg_o !== 0 || wdata_o !== 32'h66) begin
            tests_failed++;
            $display("FAIL stall_release wreg=%b wdata=%h expected 0 00000066", wreg_o, wdata_o);
        end
        tick; drive(EXE_LW_OP, 32'h500, 0, 5'd2, 1);
        tick; #1;
        tests_run++;
        if (bus_if.req !== 1 || bus_if.addr !== 32'h500) begin
            tests_failed++;
            $display("FAIL rst_access req=%b addr=%h expected 1 00000500", bus_if.req, bus_if.addr);
        end
        rst = 0;
        tick; #1;
        tests_run++;
        if ({bus_if.req, bus_if.we, bus_if.sel, bus_if.addr, bus_if.wdata, stallreq_o, wreg_o, wd_o, wdata_o} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid req=%b sel=%b addr=%h stallreq=%b wreg=%b wd=%0d wdata=%h expected all zero",
                     bus_if.req, bus_if.sel, bus_if.addr, stallreq_o, wreg_o, wd_o, wdata_o);
        end
        rst = 1; drive(EXE_ADD_OP, 32'h77, 0, 5'd6, 1); #1;
        tests_run++;
        if (wreg_o !== 1 || wdata_o !== 32'h77 || wd_o !== 5'd6 || stallreq_o !== 0) begin
            tests_failed++;
            $display("FAIL rst_idle wreg=%b wdata=%h wd=%0d stallreq=%b expected 1 00000077 6 0", wreg_o, wdata_o, wd_o, stallreq_o);
        end
    endtask

    initial begin
        test_reset;
        test_passthrough;
        test_load_byte(EXE_LB_OP, 32'hFFFF_FFF0);
        test_load_byte(EXE_LBU_OP, 32'h0000_00F0);
        test_store_half;
        test_misalign;
        test_flush_idle;
        test_flush_abort;
        test_stall_and_reset;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
